bpu_feedback_queue: RTL and testbench
=====================================

# bpu_feedback_queue

Resolution-side companion to the gshare base predictor. Records every prediction issued at fetch in an in-order queue together with the speculative global-history snapshot. Retires entries as execute resolves branches in order, and drives the predictor's PHT update strobe. On a misprediction it flushes the queue and repairs the speculative global history register.

## Interface
Parameters:
- `DEPTH`, default 8: queue entries; power of two, ≥2.
- `GHR_WIDTH`, default 32: global history width; equals the width of `` `GHR_BUS ``.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `push_valid`  in  1  fetch issues a predicted branch this cycle.
- `push_pc`  in  32  PC of the predicted branch.
- `push_pred_taken`  in  1  predictor's `taken` for that branch.
- `push_ready`  out  1  queue can accept a push (count < DEPTH).
- `resolve_valid`  in  1  execute resolves the oldest in-flight branch.
- `resolve_taken`  in  1  actual direction.
- `update_valid`  out  1  one-cycle PHT update strobe (drives predictor `branch_valid`).
- `update_taken`  out  1  actual direction (drives `branch_taken`).
- `update_pc`  out  32  PC of the resolved branch.
- `update_ghr`  out  GHR_WIDTH  history snapshot recorded at push for that branch.
- `mispredict`  out  1  one-cycle flush pulse to the frontend.
- `spec_ghr`  out  GHR_WIDTH  speculative global history fed to the predictor's `global_history_i`.
- `count`  out  log2(DEPTH)+1  occupied entries.

## Operation
- Entry fields: pc, pred_taken, ghr (value of `spec_ghr` before the push shifts it).
- Storage: circular buffer addressed by head and tail pointers, each log2(DEPTH) bits; pointers wrap modulo DEPTH.
- Push accept: `push_valid & push_ready & ~flush`.
  - Writes the entry at tail.
  - Advances tail.
  - Updates `spec_ghr <= {spec_ghr[GHR_WIDTH-2:0], push_pred_taken}`.
- Resolve accept: `resolve_valid & (count != 0)`.
  - Pops the head entry.
  - Next cycle: `update_valid=1`, `update_taken=resolve_taken`, `update_pc`/`update_ghr` taken from the head entry.
- Flush: `flush = resolve accept & (resolve_taken != head.pred_taken)`. On a flush:
  - `mispredict` pulses the next cycle.
  - head, tail and count go to 0; all entries are discarded.
  - `spec_ghr <= {head.ghr[GHR_WIDTH-2:0], resolve_taken}`.
  - A same-cycle push is dropped. Flush has priority over the push's `spec_ghr` shift.
- Push and resolve in the same cycle without a flush:
  - Both take effect.
  - count is unchanged.
  - `spec_ghr` shifts by the push only.
- Resolve while empty (count==0):
  - Ignored; no update, no mispredict, no state change.
  - A same-cycle push is still accepted.
- Full (count==DEPTH):
  - `push_ready=0`, and pushes are ignored even if a pop happens that cycle.
  - `push_ready` is derived from the registered count only.
- Count arithmetic:
  - count +1 on push-only, −1 on pop-only, 0 on flush.
  - Never exceeds DEPTH; never underflows.

## Timing
- Reset values:
  - `push_ready=1`.
  - `update_valid=0`, `update_taken=0`, `update_pc=0`, `update_ghr=0`.
  - `mispredict=0`, `spec_ghr=0`, `count=0`.
  - head and tail are 0; entry contents are don't-care.
- Reset mid-operation: wins over any same-cycle push or resolve. All in-flight entries are lost, and no update or mispredict pulse follows.
- Push at edge N:
  - `spec_ghr` and `count` reflect it from cycle N+1.
  - The entry is resolvable from cycle N+1.
  - Push-to-resolve minimum latency is 1 cycle.
- Resolve at edge M:
  - `update_*` and `mispredict` are valid during cycle M+1 only; they are registered outputs, deasserted unless re-triggered.
  - `spec_ghr` repair and queue flush are visible in cycle M+1.
- Throughput: one push and one resolve per cycle.
- Update alignment: the predictor's `FEEDBACK_LATENCY` index pipeline must match the fetch-to-update distance; this block guarantees update one cycle after resolve.

## Test plan
- Reset, then push pc=0x1000/0x1004/0x1008 with pred 1,0,1 on consecutive cycles:
  - `spec_ghr=0b101`, `count=3`.
  - Resolve 1,0,1 → three update pulses carrying those pcs and ghr snapshots 0b0, 0b1, 0b10; `mispredict` never asserts; `count=0`.
- Push pred=1 ×2 (`spec_ghr=0b11`), then resolve head with taken=0:
  - `mispredict=1` for one cycle; `update_taken=0`.
  - `spec_ghr=0b0`, `count=0`; the second entry is never updated.
- Push 8 entries with DEPTH=8:
  - `push_ready=0`.
  - A 9th push, even with a simultaneous resolve, is dropped; `count=7` after that cycle.
- At count=2, push and a correctly-predicted resolve in the same cycle:
  - `count` stays 2.
  - `spec_ghr` shifted once.
  - Update pulse carries the old head.
- Resolve with count=0 plus a same-cycle push → no update or mispredict pulse; `count=1`.
- Assert `rst` with count=5 and resolve_valid=1 → next cycle all outputs at reset values, with no update pulse.

Source files
------------

// File: rtl/bpu_feedback_queue_if.sv
// Fetch/execute-side signal bundle for the branch feedback queue.
// The master modport is the frontend/execute driver side, and the slave modport is the queue side.
interface bpu_feedback_queue_if #(
    parameter int DEPTH     = 8,
    parameter int GHR_WIDTH = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                 push_valid;
    logic [31:0]          push_pc;
    logic                 push_pred_taken;
    logic                 push_ready;
    logic                 resolve_valid;
    logic                 resolve_taken;
    logic                 update_valid;
    logic                 update_taken;
    logic [31:0]          update_pc;
    logic [GHR_WIDTH-1:0] update_ghr;
    logic                 mispredict;
    logic [GHR_WIDTH-1:0] spec_ghr;
    logic [CNT_W-1:0]     count;

    modport master (
        output push_valid, push_pc, push_pred_taken, resolve_valid, resolve_taken,
        input  push_ready, update_valid, update_taken, update_pc, update_ghr,
               mispredict, spec_ghr, count
    );

    modport slave (
        input  push_valid, push_pc, push_pred_taken, resolve_valid, resolve_taken,
        output push_ready, update_valid, update_taken, update_pc, update_ghr,
               mispredict, spec_ghr, count
    );
endinterface

// File: rtl/bpu_feedback_queue.sv
// In-order queue of issued branch predictions with their history snapshots.
// It retires entries on resolve, strobes the PHT update, and repairs the speculative GHR on a mispredict.
module bpu_feedback_queue #(
    parameter int DEPTH     = 8,
    parameter int GHR_WIDTH = 32
) (
    input logic clk,
    input logic rst,
    bpu_feedback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [31:0]          pc_mem   [DEPTH];
    logic                 pred_mem [DEPTH];
    logic [GHR_WIDTH-1:0] ghr_mem  [DEPTH];

    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count_q;
    logic [GHR_WIDTH-1:0] spec_ghr_q;
    logic                 update_valid_q;
    logic                 update_taken_q;
    logic [31:0]          update_pc_q;
    logic [GHR_WIDTH-1:0] update_ghr_q;
    logic                 mispredict_q;

    logic ready;
    logic pop;
    logic flush;
    logic push;

    // Readiness comes from the registered count only, so a same-cycle pop cannot make room.
    assign ready = (count_q != FULL);
    assign pop   = bus.resolve_valid && (count_q != '0);
    assign flush = pop && (bus.resolve_taken != pred_mem[head]);
    assign push  = bus.push_valid && ready && !flush;

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem[tail]   <= bus.push_pc;
            pred_mem[tail] <= bus.push_pred_taken;
            ghr_mem[tail]  <= spec_ghr_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head           <= '0;
            tail           <= '0;
            count_q        <= '0;
            spec_ghr_q     <= '0;
            update_valid_q <= 1'b0;
            update_taken_q <= 1'b0;
            update_pc_q    <= '0;
            update_ghr_q   <= '0;
            mispredict_q   <= 1'b0;
        end else begin
            update_valid_q <= pop;
            mispredict_q   <= flush;
            if (pop) begin
                update_taken_q <= bus.resolve_taken;
                update_pc_q    <= pc_mem[head];
                update_ghr_q   <= ghr_mem[head];
            end
            if (flush) begin
                // Rebuild history from the mispredicted branch's snapshot plus its actual outcome.
                head       <= '0;
                tail       <= '0;
                count_q    <= '0;
                spec_ghr_q <= {ghr_mem[head][GHR_WIDTH-2:0], bus.resolve_taken};
            end else begin
                if (pop)
                    head <= head + PTR_W'(1);
                if (push) begin
                    tail       <= tail + PTR_W'(1);
                    spec_ghr_q <= {spec_ghr_q[GHR_WIDTH-2:0], bus.push_pred_taken};
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + CNT_W'(1);
                    2'b01:   count_q <= count_q - CNT_W'(1);
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign bus.push_ready   = ready;
    assign bus.update_valid = update_valid_q;
    assign bus.update_taken = update_taken_q;
    assign bus.update_pc    = update_pc_q;
    assign bus.update_ghr   = update_ghr_q;
    assign bus.mispredict   = mispredict_q;
    assign bus.spec_ghr     = spec_ghr_q;
    assign bus.count        = count_q;
endmodule

// File: tb/tb_bpu_feedback_queue.sv
// Bench for bpu_feedback_queue: directed scenarios, then random traffic.
// All traffic is compared against a queue-based reference model.
module tb_bpu_feedback_queue;
    localparam int DEPTH = 8;
    localparam int GW    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bpu_feedback_queue_if #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) bus ();

    bpu_feedback_queue #(.DEPTH(DEPTH), .GHR_WIDTH(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0]   pc;
        logic          pred;
        logic [GW-1:0] ghr;
    } entry_t;

    entry_t        mq[$];
    logic [GW-1:0] m_ghr = '0;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle from the negedge, advance the model, and check just after the rising edge.
    task automatic step(input bit r, input bit pv, input logic [31:0] pc, input bit pt,
                        input bit rv, input bit rt);
        bit            e_uv, e_mis, pop, flush, push_ok;
        logic          e_ut;
        logic [31:0]   e_upc;
        logic [GW-1:0] e_ughr, old_ghr;
        entry_t        h;
        rst                 = r;
        bus.push_valid      = pv;
        bus.push_pc         = pc;
        bus.push_pred_taken = pt;
        bus.resolve_valid   = rv;
        bus.resolve_taken   = rt;
        e_uv = 0; e_mis = 0; e_ut = 0; e_upc = '0; e_ughr = '0;
        if (r) begin
            mq.delete();
            m_ghr = '0;
        end else begin
            old_ghr = m_ghr;
            pop     = rv && (mq.size() > 0);
            flush   = pop && (rt != mq[0].pred);
            push_ok = pv && (mq.size() < DEPTH) && !flush;
            if (pop) begin
                h      = mq.pop_front();
                e_uv   = 1;
                e_ut   = rt;
                e_upc  = h.pc;
                e_ughr = h.ghr;
                if (flush) begin
                    e_mis = 1;
                    mq.delete();
                    m_ghr = {h.ghr[GW-2:0], rt};
                end
            end
            if (push_ok) begin
                mq.push_back('{pc: pc, pred: pt, ghr: old_ghr});
                m_ghr = {old_ghr[GW-2:0], pt};
            end
        end
        @(posedge clk);
        #1;
        check("update_valid", 64'(bus.update_valid), 64'(e_uv));
        check("mispredict", 64'(bus.mispredict), 64'(e_mis));
        if (e_uv || r) begin
            check("update_taken", 64'(bus.update_taken), 64'(e_ut));
            check("update_pc", 64'(bus.update_pc), 64'(e_upc));
            check("update_ghr", 64'(bus.update_ghr), 64'(e_ughr));
        end
        check("spec_ghr", 64'(bus.spec_ghr), 64'(m_ghr));
        check("count", 64'(bus.count), 64'(mq.size()));
        check("push_ready", 64'(bus.push_ready), 64'(mq.size() < DEPTH));
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 32'h0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 32'h0, 0, 0, 0);
    endtask

    initial begin
        bus.push_valid = 0; bus.push_pc = '0; bus.push_pred_taken = 0;
        bus.resolve_valid = 0; bus.resolve_taken = 0;
        @(negedge clk);
        do_reset();
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_ready", 64'(bus.push_ready), 64'd1);

        // In-order pushes and correct resolves.
        step(0, 1, 32'h1000, 1, 0, 0);
        step(0, 1, 32'h1004, 0, 0, 0);
        step(0, 1, 32'h1008, 1, 0, 0);
        check("t1_ghr", 64'(bus.spec_ghr), 64'b101);
        check("t1_count", 64'(bus.count), 64'd3);
        step(0, 0, 32'h0, 0, 1, 1);
        check("t1_pc0", 64'(bus.update_pc), 64'h1000);
        step(0, 0, 32'h0, 0, 1, 0);
        check("t1_ghr1", 64'(bus.update_ghr), 64'b1);
        step(0, 0, 32'h0, 0, 1, 1);
        check("t1_ghr2", 64'(bus.update_ghr), 64'b10);
        idle();

        // Mispredict flush and history repair.
        do_reset();
        step(0, 1, 32'h2000, 1, 0, 0);
        step(0, 1, 32'h2004, 1, 0, 0);
        check("t2_ghr", 64'(bus.spec_ghr), 64'b11);
        step(0, 0, 32'h0, 0, 1, 0);
        check("t2_mis", 64'(bus.mispredict), 64'd1);
        check("t2_repair", 64'(bus.spec_ghr), 64'd0);
        step(0, 0, 32'h0, 0, 1, 1);
        idle();

        // Fill, then a push with a simultaneous resolve is dropped.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(0, 1, 32'h3000 + 32'(4 * i), i[0], 0, 0);
        check("t3_ready", 64'(bus.push_ready), 64'd0);
        step(0, 1, 32'h4000, 1, 1, 0);
        check("t3_count", 64'(bus.count), 64'd7);

        // Push plus correct resolve at count 2.
        do_reset();
        step(0, 1, 32'h5000, 0, 0, 0);
        step(0, 1, 32'h5004, 1, 0, 0);
        step(0, 1, 32'h5008, 1, 1, 0);
        check("t4_count", 64'(bus.count), 64'd2);
        check("t4_pc", 64'(bus.update_pc), 64'h5000);

        // Resolve while empty with a push.
        do_reset();
        step(0, 1, 32'h6000, 1, 1, 0);
        check("t5_count", 64'(bus.count), 64'd1);

        // Reset mid-flight.
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 1, 32'h7000 + 32'(4 * i), 1, 0, 0);
        step(1, 1, 32'h8000, 1, 1, 0);
        check("t6_count", 64'(bus.count), 64'd0);
        idle();

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            bit r, pv, pt, rv, rt;
            r  = ($urandom_range(0, 199) == 0);
            pv = ($urandom_range(0, 99) < 60);
            pt = $urandom_range(0, 1);
            rv = ($urandom_range(0, 99) < 50);
            if (mq.size() > 0 && $urandom_range(0, 99) < 88) rt = mq[0].pred;
            else rt = $urandom_range(0, 1);
            step(r, pv, $urandom, pt, rv, rt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
